// File: rtl/vga_tile_buffer_if.sv
// Tile-buffer bus: CPU tile-write/fill port plus the VGA pixel read port.
interface vga_tile_buffer_if #(
    parameter int unsigned ADDR_W = 13
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [11:0]       wr_data;
    logic              fill_start;
    logic [11:0]       fill_color;
    logic              busy;
    logic              addr_err;
    logic [8:0]        row;
    logic [9:0]        column;
    logic              read;
    logic [11:0]       data;

    // CPU / timing-port side
    modport master (
        output wr_valid, wr_addr, wr_data, fill_start, fill_color, row, column, read,
        input  wr_ready, busy, addr_err, data
    );

    // Tile buffer side
    modport slave (
        input  wr_valid, wr_addr, wr_data, fill_start, fill_color, row, column, read,
        output wr_ready, busy, addr_err, data
    );
endinterface

// File: rtl/vga_tile_buffer.sv
// 80x60 tile colour buffer: zero-latency pixel read, FIFO-buffered CPU writes,
// and a hardware full-screen fill that first drains any queued writes.
module vga_tile_buffer #(
    parameter int unsigned COLS       = 80,
    parameter int unsigned ROWS       = 60,
    parameter int unsigned ADDR_W     = 13,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic               clk,
    input logic               rst,
    vga_tile_buffer_if.slave  bus
);
    localparam int unsigned TILES = COLS * ROWS;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned COL_W = 12;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRAIN = 2'd1;
    localparam logic [1:0] FILL  = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_n;
    logic              ready_q;
    logic              ready_n;
    logic              busy_q;
    logic              busy_n;
    logic              err_q;
    logic              fill_load;
    logic              last_fill;
    logic [COL_W-1:0]  fill_col;
    logic [ADDR_W-1:0] fill_addr;

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [COL_W-1:0]  fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_n;
    logic              full_n;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] head_addr;
    logic [COL_W-1:0]  head_data;
    logic              head_ok;

    logic [COL_W-1:0]  mem [TILES];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [COL_W-1:0]  mem_wdata;
    logic [ADDR_W-1:0] rd_addr;
    logic              unused_bits;

    // FIFO handshake and next occupancy
    always_comb begin
        push      = bus.wr_valid & ready_q;
        pop       = ((state == IDLE) || (state == DRAIN)) && (count != '0);
        head_addr = fifo_addr[rd_ptr];
        head_data = fifo_data[rd_ptr];
        head_ok   = head_addr < ADDR_W'(TILES);
        count_n   = count;
        case ({push, pop})
            2'b10:   count_n = count + CNT_W'(1);
            2'b01:   count_n = count - CNT_W'(1);
            default: count_n = count;
        endcase
        full_n = (count_n == CNT_W'(FIFO_DEPTH));
    end

    // Next state plus next values of the registered status outputs
    always_comb begin
        state_n   = state;
        fill_load = 1'b0;
        last_fill = (fill_addr == ADDR_W'(TILES - 1));
        case (state)
            IDLE: begin
                if (bus.fill_start) begin
                    fill_load = 1'b1;
                    state_n   = (count_n != '0) ? DRAIN : FILL;
                end
            end
            DRAIN: begin
                if (count_n == '0) begin
                    state_n = FILL;
                end
            end
            FILL: begin
                if (last_fill) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        busy_n  = (state_n != IDLE);
        ready_n = !full_n && (state_n != FILL);
    end

    // Control registers: FSM, FIFO pointers, status flags, fill counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fill_col  <= '0;
            fill_addr <= '0;
        end else begin
            state   <= state_n;
            ready_q <= ready_n;
            busy_q  <= busy_n;
            count   <= count_n;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (pop && !head_ok) begin
                err_q <= 1'b1;
            end
            if (fill_load) begin
                fill_col <= bus.fill_color;
            end
            fill_addr <= ((state == FILL) && !last_fill) ? fill_addr + ADDR_W'(1) : '0;
        end
    end

    // FIFO storage; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= bus.wr_addr;
            fifo_data[wr_ptr] <= bus.wr_data;
        end
    end

    // RAM write port: fill has priority, otherwise the in-range FIFO head
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = fill_addr;
        mem_wdata = fill_col;
        if (state == FILL) begin
            mem_we = 1'b1;
        end else if (pop && head_ok) begin
            mem_we    = 1'b1;
            mem_waddr = head_addr;
            mem_wdata = head_data;
        end
    end

    // Tile RAM, deliberately not reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Combinational pixel read: tile index from the upper row/column bits
    always_comb begin
        rd_addr = ADDR_W'(bus.row[8:3]) * ADDR_W'(COLS) + ADDR_W'(bus.column[9:3]);
    end

    assign unused_bits  = ^{bus.row[2:0], bus.column[2:0]};
    assign bus.data     = bus.read ? mem[rd_addr] : '0;
    assign bus.wr_ready = ready_q;
    assign bus.busy     = busy_q;
    assign bus.addr_err = err_q;
endmodule

// File: tb/tb_vga_tile_buffer.sv
// Directed bench for vga_tile_buffer: read-vector table plus multi-cycle sequences.
module tb_vga_tile_buffer;
    localparam int unsigned TILES = 4800;

    typedef struct {
        logic [8:0]  row;
        logic [9:0]  column;
        logic        rd;
        logic [11:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n;
    int   rdy_hi;
    int   s;
    logic [11:0] model [TILES];
    vec_t vecs [11];

    always #20 clk = ~clk;

    vga_tile_buffer_if #(.ADDR_W(13)) bus ();

    vga_tile_buffer #(
        .COLS(80), .ROWS(60), .ADDR_W(13), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push_word(input logic [12:0] a, input logic [11:0] d, output int stalls);
        logic took;
        bus.wr_valid = 1'b1;
        bus.wr_addr  = a;
        bus.wr_data  = d;
        stalls = 0;
        took   = 1'b0;
        while (!took && stalls <= 6000) begin
            took = bus.wr_ready;
            @(negedge clk);
            if (!took) stalls++;
        end
        if (!took) check("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_fill(input logic [11:0] c);
        bus.fill_start = 1'b1;
        bus.fill_color = c;
        @(negedge clk);
        bus.fill_start = 1'b0;
    endtask

    // Counts busy cycles; optionally re-pulses fill_start mid-fill.
    task automatic busy_len(input int inject_at, output int len, output int ready_hi);
        len = 0;
        ready_hi = 0;
        while (bus.busy && len < 10000) begin
            len++;
            if (bus.wr_ready) ready_hi++;
            bus.fill_start = (len == inject_at);
            bus.fill_color = 12'hEEE;
            @(negedge clk);
        end
        bus.fill_start = 1'b0;
    endtask

    task automatic scan(input string name);
        int bad;
        bad = 0;
        for (int t = 0; t < int'(TILES); t++) begin
            @(negedge clk);
            bus.read   = 1'b1;
            bus.row    = 9'((t / 80) * 8 + (t % 8));
            bus.column = 10'((t % 80) * 8 + 7 - (t % 8));
            #1;
            if (bus.data !== model[t]) bad++;
        end
        bus.read = 1'b0;
        check(name, 32'(bad), 32'd0);
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{9'd8,   10'd8,   1'b1, 12'h0F0};
        vecs[1]  = '{9'd15,  10'd15,  1'b1, 12'h0F0};
        vecs[2]  = '{9'd12,  10'd10,  1'b1, 12'h0F0};
        vecs[3]  = '{9'd8,   10'd16,  1'b1, 12'hF00};
        vecs[4]  = '{9'd8,   10'd7,   1'b1, 12'hF00};
        vecs[5]  = '{9'd7,   10'd8,   1'b1, 12'hF00};
        vecs[6]  = '{9'd16,  10'd8,   1'b1, 12'hF00};
        vecs[7]  = '{9'd0,   10'd0,   1'b1, 12'hF00};
        vecs[8]  = '{9'd479, 10'd639, 1'b1, 12'hF00};
        vecs[9]  = '{9'd8,   10'd8,   1'b0, 12'h000};
        vecs[10] = '{9'd479, 10'd639, 1'b0, 12'h000};

        rst = 1'b0;
        bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.fill_start = 1'b0; bus.fill_color = '0;
        bus.row = '0; bus.column = '0; bus.read = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_err", 32'(bus.addr_err), 32'd0);
        check("rst_ready", 32'(bus.wr_ready), 32'd0);
        check("rst_data_noread", 32'(bus.data), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_release", 32'(bus.wr_ready), 32'd1);

        // Full-screen fill from an empty FIFO
        pulse_fill(12'hF00);
        for (int t = 0; t < int'(TILES); t++) model[t] = 12'hF00;
        busy_len(-1, n, rdy_hi);
        check("fill_len", 32'(n), 32'd4800);
        check("fill_ready_low", 32'(rdy_hi), 32'd0);
        check("ready_after_fill", 32'(bus.wr_ready), 32'd1);
        scan("scan_f00");

        // Single write; old value visible until the RAM write edge
        @(negedge clk);
        push_word(13'd81, 12'h0F0, s);
        bus.wr_valid = 1'b0;
        bus.read = 1'b1; bus.row = 9'd8; bus.column = 10'd8;
        #1;
        check("old_before_edge", 32'(bus.data), 32'hF00);
        model[81] = 12'h0F0;
        @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            bus.row = vecs[i].row; bus.column = vecs[i].column; bus.read = vecs[i].rd;
            #1;
            check($sformatf("vec%0d", i), 32'(bus.data), 32'(vecs[i].exp));
        end
        bus.read = 1'b0;

        // Out-of-range write is dropped and flags a sticky error
        @(negedge clk);
        check("err_clear", 32'(bus.addr_err), 32'd0);
        push_word(13'd4800, 12'hABC, s);
        bus.wr_valid = 1'b0;
        @(negedge clk);
        check("err_set", 32'(bus.addr_err), 32'd1);
        repeat (5) @(negedge clk);
        check("err_sticky", 32'(bus.addr_err), 32'd1);
        bus.read = 1'b1; bus.row = 9'd0; bus.column = 10'd0;
        #1;
        check("tile0_after_err", 32'(bus.data), 32'hF00);
        bus.read = 1'b0;

        // Write stalled by a fill, then back-to-back writes after it
        @(negedge clk);
        pulse_fill(12'h123);
        for (int t = 0; t < int'(TILES); t++) model[t] = 12'h123;
        push_word(13'd200, 12'h456, s);
        check("stall_cycles", 32'(s), 32'd4800);
        check("stall_busy_done", 32'(bus.busy), 32'd0);
        model[200] = 12'h456;
        for (int i = 1; i < 5; i++) begin
            push_word(13'(200 + i), 12'(12'h456 + i), s);
            check($sformatf("b2b_stall%0d", i), 32'(s), 32'd0);
            model[200 + i] = 12'(12'h456 + i);
        end
        bus.wr_valid = 1'b0;
        repeat (2) @(negedge clk);
        scan("scan_stall");

        // Write in the fill_start cycle is overwritten; re-pulse while busy ignored
        @(negedge clk);
        bus.wr_valid = 1'b1; bus.wr_addr = 13'd5; bus.wr_data = 12'h00F;
        bus.fill_start = 1'b1; bus.fill_color = 12'h111;
        @(negedge clk);
        bus.wr_valid = 1'b0; bus.fill_start = 1'b0;
        for (int t = 0; t < int'(TILES); t++) model[t] = 12'h111;
        busy_len(10, n, rdy_hi);
        check("fill_len_drain", 32'(n), 32'd4801);
        check("drain_ready_cycles", 32'(rdy_hi), 32'd1);
        bus.read = 1'b1; bus.row = 9'd0; bus.column = 10'd40;
        #1;
        check("tile5_fill_wins", 32'(bus.data), 32'h111);
        bus.read = 1'b0;
        scan("scan_111");

        // Reset after 100 fill writes
        @(negedge clk);
        check("err_kept", 32'(bus.addr_err), 32'd1);
        pulse_fill(12'h777);
        repeat (100) @(negedge clk);
        check("busy_mid_fill", 32'(bus.busy), 32'd1);
        rst = 1'b0;
        #1;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_ready", 32'(bus.wr_ready), 32'd0);
        check("midrst_err", 32'(bus.addr_err), 32'd0);
        repeat (2) @(negedge clk);
        check("midrst_ready_held", 32'(bus.wr_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ready_release", 32'(bus.wr_ready), 32'd1);
        check("midrst_busy_release", 32'(bus.busy), 32'd0);
        for (int t = 0; t < 100; t++) model[t] = 12'h777;
        scan("scan_reset_mid_fill");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/vga_tile_buffer.md
Name: vga_tile_buffer

Overview:
- Pixel source feeding the VGA timing port.
- Answers that port's row/column/read request with 12-bit RGB combinationally, in the same cycle.
- Image is an 80x60 grid of 8x8-pixel tiles, one 12-bit colour per tile, held in distributed RAM.
- CPU side writes tiles through a valid/ready port with a small write FIFO, and can request a hardware fill of the whole screen with one colour.

Parameters:
- COLS, 80, tiles per line (640/8).
- ROWS, 60, tile lines (480/8).
- ADDR_W, 13, tile address width (COLS*ROWS = 4800 <= 8192).
- FIFO_DEPTH, 4, write FIFO entries (power of two).

Ports:
- clk  in  1  pixel clock, 25 MHz, same clock as the VGA timing port.
- rst  in  1  asynchronous, active-low reset (block in reset while rst=0).
- wr_valid  in  1  CPU tile-write request.
- wr_ready  out  1  FIFO can accept; a transfer occurs when wr_valid & wr_ready at a rising edge.
- wr_addr  in  ADDR_W  tile index, row*COLS+col.
- wr_data  in  12  tile colour {r,g,b}.
- fill_start  in  1  one-cycle pulse requesting a full-screen fill.
- fill_color  in  12  fill colour, sampled with fill_start.
- busy  out  1  fill pending or in progress.
- addr_err  out  1  sticky: a write with wr_addr >= COLS*ROWS was accepted and discarded.
- row  in  9  visible pixel row from the timing port.
- column  in  10  visible pixel column from the timing port.
- read  in  1  timing port is in the visible area.
- data  out  12  pixel colour to the timing port.

Behaviour:
- Reset (rst=0, async):
  - FIFO emptied; state IDLE.
  - busy=0, addr_err=0, wr_ready=0 while held, 1 in the first cycle after release.
  - RAM contents are not reset (undefined until written or filled).
  - data follows the combinational rule below.
- Read path (purely combinational, zero latency):
  - addr = row[8:3]*COLS + column[9:3].
  - data = read ? mem[addr] : 12'h000.
  - row/column are don't-care when read=0. Out-of-range addresses cannot occur while read=1.
- Write FIFO:
  - wr_ready = !full & (state != FILL).
  - Push on handshake. Pop one entry per cycle while state is IDLE or DRAIN and the FIFO is non-empty.
  - A popped entry with addr < 4800 writes mem. Otherwise it is dropped and addr_err is set.
  - An entry pushed at edge N is written at edge N+1 at the earliest. It is visible on data from cycle N+1 onward.
  - Push and pop in the same cycle are allowed; count is unchanged.
  - Push while full is impossible (wr_ready=0).
- FSM:
  - IDLE:
    - fill_start=1 latches fill_color and sets busy=1 from the next cycle.
    - Goes to DRAIN if the FIFO will be non-empty after this edge, else to FILL.
  - DRAIN: pops until empty, then goes to FILL. wr_ready follows !full, so new writes are still accepted and drained before the fill.
  - FILL:
    - Writes latched colour to addresses 0..4799, one per cycle (4800 cycles). wr_ready=0.
    - After writing address 4799, goes to IDLE; busy=0 in that same next cycle.
  - fill_start is ignored while busy=1.
- Ordering:
  - Any write accepted before or in the same cycle as fill_start is overwritten by the fill.
  - Writes accepted after FILL ends land after it.
- The RAM read port is independent of the write port. On a same-cycle read and write of the same tile, data shows the old value until the edge.
- Reset mid-FILL or mid-DRAIN: returns to IDLE immediately. Pending FIFO entries are lost; tiles already written keep their values.

Test Plan:
- Reset then fill_start with fill_color=12'hF00 -> busy=1 for exactly 4800 cycles, wr_ready=0 throughout. Afterwards every visible pixel reads 12'hF00, and data=0 whenever read=0.
- Write addr 81, data 12'h0F0 -> pixel (row 8..15, column 8..15) reads 12'h0F0 the cycle after the handshake. Pixel column 16 on the same row still reads 12'hF00.
- Hold wr_valid with wr_ready stalled by a fill -> no transfer until busy=0. Five back-to-back writes -> all five land, none lost or duplicated.
- Write addr 4800 -> addr_err=1 and stays set; RAM unchanged, including tile 0.
- Write addr 5 (12'h00F) in the same cycle as fill_start (12'h111) -> tile 5 ends 12'h111. fill_start during busy -> ignored, fill length still 4800.
- Drop rst to 0 at fill cycle 100 -> busy=0 and wr_ready=0 immediately while rst=0, wr_ready=1 after release. Tiles 0..99 hold the fill colour; the rest are unchanged.
